adc_arbiter: RTL and testbench

ADC_ARBITER -- requirements
Module: adc_arbiter

---
 rtl/adc_pkg.sv | 41 ++++
 rtl/rr_picker.sv | 50 +++++
 rtl/adc_arbiter.sv | 259 +++++++++++++++++++++++++
 tb/tb_adc_arbiter.sv | 369 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_pkg.sv
// ----------------------------------------------------------------------------
// adc_pkg
// Shared definitions for the modular-ADC arbiter:
//   - adc_state_e        : arbiter FSM states
//   - ADC_CH_W/ADC_DATA_W: channel and sample widths of the ADC Avalon-ST links
//   - ADC_CH_TSD         : channel number of the temperature-sense diode
//   - adc_offset_correct : saturating raw-code offset removal
// ----------------------------------------------------------------------------
package adc_pkg;

    localparam int ADC_CH_W   = 5;
    localparam int ADC_DATA_W = 12;

    localparam logic [ADC_CH_W-1:0] ADC_CH_TSD = 5'd17;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ISSUE    = 2'd1,
        ST_WAIT_RSP = 2'd2,
        ST_DONE     = 2'd3
    } adc_state_e;

    // Subtracts the offset from a raw sample, clamping at zero. With en low
    // the raw sample passes through untouched.
    function automatic logic [ADC_DATA_W-1:0] adc_offset_correct(
        input logic [ADC_DATA_W-1:0] raw,
        input logic [ADC_DATA_W-1:0] off,
        input logic                  en
    );
        logic [ADC_DATA_W-1:0] res;
        if (!en) begin
            res = raw;
        end else if (raw < off) begin
            res = 12'd0;
        end else begin
            res = raw - off;
        end
        return res;
    endfunction

endpackage

// File: rtl/rr_picker.sv
// ----------------------------------------------------------------------------
// rr_picker
// Combinational round-robin selector. The search starts at the requester
// after last_idx and wraps, so the last winner has the lowest priority.
// Ports:
//   req      in  NUM_REQ  request vector
//   last_idx in  IDX_W    index of the previously granted requester
//   grant    out NUM_REQ  one-hot winner (zero when no request)
//   idx      out IDX_W    binary index of the winner
//   valid    out 1        at least one request present
// ----------------------------------------------------------------------------
module rr_picker #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last_idx,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   idx,
    output logic               valid
);

    logic [NUM_REQ-1:0] grant_s;
    logic [IDX_W-1:0]   idx_s;
    logic               found_s;
    logic [IDX_W-1:0]   pos_s;

    // Rotating priority search beginning just after the last winner.
    always_comb begin
        grant_s = '0;
        idx_s   = '0;
        found_s = 1'b0;
        pos_s   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            pos_s = IDX_W'((int'(last_idx) + k) % NUM_REQ);
            if (!found_s && req[pos_s]) begin
                found_s        = 1'b1;
                grant_s[pos_s] = 1'b1;
                idx_s          = pos_s;
            end else begin
                found_s = found_s;
            end
        end
    end

    assign grant = grant_s;
    assign idx   = idx_s;
    assign valid = found_s;

endmodule

// File: rtl/adc_arbiter.sv
// ----------------------------------------------------------------------------
// adc_arbiter
// Shares one modular ADC between NUM_REQ requesters. A winner is picked
// round-robin, its channel is sent as a command, the matching response (or a
// timeout) completes the transaction with a one-cycle done pulse.
// All outputs are registered; they are computed from the next state so that
// each output is valid in the same cycle as the state it belongs to.
//
// Optional feature macro: ADC_ARB_OFFSET_EN -- when defined, result_data is
// rsp_data - OFFSET saturated at zero; otherwise rsp_data passes unchanged.
//
// Ports:
//   clock_in     in  1            system clock
//   reset_n      in  1            asynchronous active-low reset
//   req          in  NUM_REQ      level request per requester
//   req_channel  in  5*NUM_REQ    channel per requester ([5i+4:5i])
//   grant        out NUM_REQ      one-hot, high while transaction in flight
//   done         out NUM_REQ      one-cycle completion pulse
//   result_data  out 12           sample, valid with done
//   result_err   out 1            timeout flag, valid with done
//   cmd_valid    out 1            ADC command valid
//   cmd_channel  out 5            ADC command channel
//   cmd_ready    in  1            ADC command ready
//   rsp_valid    in  1            ADC response valid
//   rsp_channel  in  5            ADC response channel
//   rsp_data     in  12           ADC response sample
//   busy         out 1            arbiter not idle
// ----------------------------------------------------------------------------
module adc_arbiter
    import adc_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 1023,
    parameter int OFFSET         = 3431
) (
    input  logic                           clock_in,
    input  logic                           reset_n,
    input  logic [NUM_REQ-1:0]             req,
    input  logic [ADC_CH_W*NUM_REQ-1:0]    req_channel,
    output logic [NUM_REQ-1:0]             grant,
    output logic [NUM_REQ-1:0]             done,
    output logic [ADC_DATA_W-1:0]          result_data,
    output logic                           result_err,
    output logic                           cmd_valid,
    output logic [ADC_CH_W-1:0]            cmd_channel,
    input  logic                           cmd_ready,
    input  logic                           rsp_valid,
    input  logic [ADC_CH_W-1:0]            rsp_channel,
    input  logic [ADC_DATA_W-1:0]          rsp_data,
    output logic                           busy
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [ADC_DATA_W-1:0] OFFSET_W = ADC_DATA_W'(OFFSET);

`ifdef ADC_ARB_OFFSET_EN
    localparam logic OFFSET_ON = 1'b1;
`else
    localparam logic OFFSET_ON = 1'b0;
`endif

    adc_state_e              state_r;
    adc_state_e              state_nx;

    logic [IDX_W-1:0]        idx_r;
    logic [IDX_W-1:0]        idx_nx;
    logic [ADC_CH_W-1:0]     ch_r;
    logic [ADC_CH_W-1:0]     ch_nx;
    logic [IDX_W-1:0]        last_r;
    logic [CNT_W-1:0]        cnt_r;
    logic [CNT_W-1:0]        cnt_inc_s;

    logic [NUM_REQ-1:0]      pick_grant_s;
    logic [IDX_W-1:0]        pick_idx_s;
    logic                    pick_valid_s;

    logic                    accept_s;
    logic                    rsp_hit_s;
    logic                    timeout_hit_s;

    logic [NUM_REQ-1:0]      grant_r,       grant_nx;
    logic [NUM_REQ-1:0]      done_r,        done_nx;
    logic [ADC_DATA_W-1:0]   result_data_r, result_data_nx;
    logic                    result_err_r,  result_err_nx;
    logic                    cmd_valid_r,   cmd_valid_nx;
    logic [ADC_CH_W-1:0]     cmd_channel_r, cmd_channel_nx;
    logic                    busy_r,        busy_nx;

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_picker (
        .req      (req),
        .last_idx (last_r),
        .grant    (pick_grant_s),
        .idx      (pick_idx_s),
        .valid    (pick_valid_s)
    );

    // cmd_valid is high exactly while in ISSUE, so acceptance needs only the state.
    assign accept_s      = (state_r == ST_ISSUE) && cmd_ready;
    assign rsp_hit_s     = (state_r == ST_WAIT_RSP) && rsp_valid && (rsp_channel == ch_r);
    assign cnt_inc_s     = cnt_r + CNT_W'(1);
    assign timeout_hit_s = (state_r == ST_WAIT_RSP) && (cnt_inc_s == CNT_W'(TIMEOUT_CYCLES));

    // FSM state register.
    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx;
        end
    end

    // FSM next-state logic; a matching response outranks a timeout in the same cycle.
    always_comb begin
        state_nx = state_r;
        case (state_r)
            ST_IDLE: begin
                if (pick_valid_s) begin
                    state_nx = ST_ISSUE;
                end else begin
                    state_nx = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (accept_s) begin
                    state_nx = ST_WAIT_RSP;
                end else begin
                    state_nx = ST_ISSUE;
                end
            end
            ST_WAIT_RSP: begin
                if (rsp_hit_s || timeout_hit_s) begin
                    state_nx = ST_DONE;
                end else begin
                    state_nx = ST_WAIT_RSP;
                end
            end
            ST_DONE: begin
                state_nx = ST_IDLE;
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    // Winner index and channel are latched only in IDLE; req is ignored otherwise.
    always_comb begin
        idx_nx = idx_r;
        ch_nx  = ch_r;
        if ((state_r == ST_IDLE) && pick_valid_s) begin
            idx_nx = pick_idx_s;
            ch_nx  = req_channel[pick_idx_s*ADC_CH_W +: ADC_CH_W];
        end else begin
            idx_nx = idx_r;
            ch_nx  = ch_r;
        end
    end

    // Latched transaction context, round-robin pointer and response timer.
    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            idx_r  <= '0;
            ch_r   <= '0;
            last_r <= IDX_W'(NUM_REQ - 1);
            cnt_r  <= '0;
        end else begin
            idx_r <= idx_nx;
            ch_r  <= ch_nx;
            if (state_r == ST_DONE) begin
                last_r <= idx_r;
            end else begin
                last_r <= last_r;
            end
            if (accept_s) begin
                cnt_r <= '0;
            end else if (state_r == ST_WAIT_RSP) begin
                cnt_r <= cnt_inc_s;
            end else begin
                cnt_r <= cnt_r;
            end
        end
    end

    // FSM output logic: next values of the registered outputs.
    always_comb begin
        grant_nx       = '0;
        done_nx        = '0;
        result_data_nx = result_data_r;
        result_err_nx  = 1'b0;
        cmd_valid_nx   = 1'b0;
        cmd_channel_nx = '0;
        busy_nx        = (state_nx != ST_IDLE);

        if (state_nx == ST_IDLE) begin
            grant_nx = '0;
        end else if (state_r == ST_IDLE) begin
            grant_nx = pick_grant_s;
        end else begin
            grant_nx = grant_r;
        end

        if (state_nx == ST_ISSUE) begin
            cmd_valid_nx   = 1'b1;
            cmd_channel_nx = ch_nx;
        end else begin
            cmd_valid_nx   = 1'b0;
            cmd_channel_nx = '0;
        end

        if ((state_r == ST_WAIT_RSP) && (state_nx == ST_DONE)) begin
            done_nx = grant_r;
            if (rsp_hit_s) begin
                result_data_nx = adc_offset_correct(rsp_data, OFFSET_W, OFFSET_ON);
                result_err_nx  = 1'b0;
            end else begin
                result_data_nx = '0;
                result_err_nx  = 1'b1;
            end
        end else begin
            done_nx        = '0;
            result_data_nx = result_data_r;
            result_err_nx  = 1'b0;
        end
    end

    // Output registers.
    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            grant_r       <= '0;
            done_r        <= '0;
            result_data_r <= '0;
            result_err_r  <= 1'b0;
            cmd_valid_r   <= 1'b0;
            cmd_channel_r <= '0;
            busy_r        <= 1'b0;
        end else begin
            grant_r       <= grant_nx;
            done_r        <= done_nx;
            result_data_r <= result_data_nx;
            result_err_r  <= result_err_nx;
            cmd_valid_r   <= cmd_valid_nx;
            cmd_channel_r <= cmd_channel_nx;
            busy_r        <= busy_nx;
        end
    end

    assign grant       = grant_r;
    assign done        = done_r;
    assign result_data = result_data_r;
    assign result_err  = result_err_r;
    assign cmd_valid   = cmd_valid_r;
    assign cmd_channel = cmd_channel_r;
    assign busy        = busy_r;

endmodule

// File: tb/tb_adc_arbiter.sv
// ----------------------------------------------------------------------------
// tb_adc_arbiter
// Self-checking bench for adc_arbiter: directed scenarios with literal
// expectations followed by randomized traffic, all compared every cycle
// against a transaction-level model of the arbitration rules.
// ----------------------------------------------------------------------------
module tb_adc_arbiter;
    import adc_pkg::*;

    localparam int N = 4;
    localparam int T = 16;

    logic              clk;
    logic              rst_n;
    logic [N-1:0]      req;
    logic [5*N-1:0]    req_channel;
    logic [N-1:0]      grant;
    logic [N-1:0]      done;
    logic [11:0]       result_data;
    logic              result_err;
    logic              cmd_valid;
    logic [4:0]        cmd_channel;
    logic              cmd_ready;
    logic              rsp_valid;
    logic [4:0]        rsp_channel;
    logic [11:0]       rsp_data;
    logic              busy;

    int n_cmp = 0;
    int n_bad = 0;

    // Model state: current transaction, if any.
    int          m_active;
    int          m_owner;
    int          m_accepted;
    int          m_waited;
    int          m_fin;
    int          m_last;
    logic [4:0]  m_ch;
    logic [11:0] m_data;
    logic        m_err;

    adc_arbiter #(
        .NUM_REQ        (N),
        .TIMEOUT_CYCLES (T),
        .OFFSET         (3431)
    ) dut (
        .clock_in    (clk),
        .reset_n     (rst_n),
        .req         (req),
        .req_channel (req_channel),
        .grant       (grant),
        .done        (done),
        .result_data (result_data),
        .result_err  (result_err),
        .cmd_valid   (cmd_valid),
        .cmd_channel (cmd_channel),
        .cmd_ready   (cmd_ready),
        .rsp_valid   (rsp_valid),
        .rsp_channel (rsp_channel),
        .rsp_data    (rsp_data),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [11:0] corr(input logic [11:0] raw);
`ifdef ADC_ARB_OFFSET_EN
        if (int'(raw) < 3431) return 12'd0;
        return 12'(int'(raw) - 3431);
`else
        return raw;
`endif
    endfunction

    function automatic int pick(input logic [N-1:0] r, input int last);
        for (int k = 1; k <= N; k++) begin
            if (r[(last + k) % N]) return (last + k) % N;
        end
        return -1;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        m_active   = 0;
        m_owner    = 0;
        m_accepted = 0;
        m_waited   = 0;
        m_fin      = 0;
        m_last     = N - 1;
        m_ch       = 5'd0;
        m_data     = 12'd0;
        m_err      = 1'b0;
    endtask

    // Advance the model by one clock using the inputs the DUT just sampled.
    task automatic model_edge();
        int w;
        w = -1;
        if (m_active == 0) begin
            w = pick(req, m_last);
            if (w >= 0) begin
                m_active   = 1;
                m_owner    = w;
                m_ch       = req_channel[w*5 +: 5];
                m_accepted = 0;
                m_waited   = 0;
                m_fin      = 0;
            end
        end else if (m_accepted == 0) begin
            if (cmd_ready) m_accepted = 1;
        end else if (m_fin == 0) begin
            m_waited++;
            if (rsp_valid && rsp_channel == m_ch) begin
                m_fin  = 1;
                m_err  = 1'b0;
                m_data = corr(rsp_data);
            end else if (m_waited == T) begin
                m_fin  = 1;
                m_err  = 1'b1;
                m_data = 12'd0;
            end
        end else begin
            m_active = 0;
            m_fin    = 0;
            m_last   = m_owner;
        end
    endtask

    task automatic compare_all();
        logic [N-1:0] eg;
        logic         ev;
        eg = '0;
        if (m_active != 0) eg[m_owner] = 1'b1;
        ev = (m_active != 0) && (m_accepted == 0);
        check("grant", 32'(grant), 32'(eg));
        check("done", 32'(done), (m_fin != 0) ? 32'(eg) : 32'd0);
        check("busy", 32'(busy), 32'(m_active != 0));
        check("cmd_valid", 32'(cmd_valid), 32'(ev));
        check("cmd_channel", 32'(cmd_channel), ev ? 32'(m_ch) : 32'd0);
        check("result_err", 32'(result_err), (m_fin != 0) ? 32'(m_err) : 32'd0);
        if (m_fin != 0) check("result_data", 32'(result_data), 32'(m_data));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    // Reset asserted asynchronously away from the clock edge.
    task automatic do_reset();
        req       = '0;
        cmd_ready = 1'b0;
        rsp_valid = 1'b0;
        rst_n     = 1'b0;
        #1;
        check("rst_grant", 32'(grant), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_cmd_valid", 32'(cmd_valid), 32'd0);
        check("rst_cmd_channel", 32'(cmd_channel), 32'd0);
        check("rst_result", 32'(result_data), 32'd0);
        check("rst_err", 32'(result_err), 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Responder driven from the model: answer while a transaction waits.
    task automatic auto_rsp();
        rsp_valid   = (m_active != 0) && (m_accepted != 0) && (m_fin == 0);
        rsp_channel = m_ch;
        rsp_data    = 12'(1000 + 100 * m_owner);
    endtask

    function automatic int oh_idx(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return -1;
    endfunction

    initial begin
        int order [5];
        int cnt;
        logic [N-1:0] prev_g;

        rst_n       = 1'b0;
        req         = '0;
        req_channel = '0;
        cmd_ready   = 1'b0;
        rsp_valid   = 1'b0;
        rsp_channel = 5'd0;
        rsp_data    = 12'd0;
        model_reset();
        #2;

        // Basic transaction with minimum latency; req drops after grant.
        do_reset();
        req_channel[4:0] = ADC_CH_TSD;
        req = 4'b0001;
        cmd_ready = 1'b1;
        step();
        check("t1_grant", 32'(grant), 32'h1);
        req = 4'b0000;
        step();
        check("t1_no_done_yet", 32'(done), 32'd0);
        rsp_valid = 1'b1; rsp_channel = 5'd17; rsp_data = 12'd3500;
        step();
        check("t1_done", 32'(done), 32'h1);
`ifdef ADC_ARB_OFFSET_EN
        check("t1_data", 32'(result_data), 32'd69);
`else
        check("t1_data", 32'(result_data), 32'd3500);
`endif
        rsp_valid = 1'b0;
        step();
        check("t1_done_pulse", 32'(done), 32'd0);

        // All four requesting: round-robin order 0,1,2,3,0.
        do_reset();
        for (int i = 0; i < N; i++) req_channel[i*5 +: 5] = 5'(i + 3);
        req = 4'b1111;
        cmd_ready = 1'b1;
        cnt = 0;
        prev_g = '0;
        for (int i = 0; i < 5; i++) order[i] = -1;
        for (int c = 0; c < 60 && cnt < 5; c++) begin
            auto_rsp();
            step();
            if (grant != 0 && prev_g == 0) begin
                order[cnt] = oh_idx(grant);
                cnt++;
            end
            prev_g = grant;
        end
        check("rr_0", 32'(order[0]), 32'd0);
        check("rr_1", 32'(order[1]), 32'd1);
        check("rr_2", 32'(order[2]), 32'd2);
        check("rr_3", 32'(order[3]), 32'd3);
        check("rr_4", 32'(order[4]), 32'd0);
        rsp_valid = 1'b0;

        // Backpressure for 10 cycles, then timeout with no response.
        do_reset();
        req_channel[4:0] = 5'd17;
        req = 4'b0001;
        step();
        req = 4'b0000;
        for (int c = 0; c < 10; c++) begin
            step();
            check("bp_cmd_valid", 32'(cmd_valid), 32'd1);
            check("bp_cmd_channel", 32'(cmd_channel), 32'd17);
        end
        cmd_ready = 1'b1;
        step();
        cmd_ready = 1'b0;
        for (int c = 0; c < T - 1; c++) step();
        check("to_not_early", 32'(done), 32'd0);
        step();
        check("to_done", 32'(done), 32'h1);
        check("to_err", 32'(result_err), 32'd1);
        check("to_data", 32'(result_data), 32'd0);
        step();

        // Mismatched channel ignored, matching channel captured.
        do_reset();
        req_channel[4:0] = 5'd17;
        req = 4'b0001;
        cmd_ready = 1'b1;
        step();
        step();
        rsp_valid = 1'b1; rsp_channel = 5'd5; rsp_data = 12'd1111;
        step();
        check("mm_ignored", 32'(done), 32'd0);
        rsp_channel = 5'd17; rsp_data = 12'd4000;
        step();
        check("mm_done", 32'(done), 32'h1);
        check("mm_err", 32'(result_err), 32'd0);
`ifdef ADC_ARB_OFFSET_EN
        check("mm_data", 32'(result_data), 32'd569);
`else
        check("mm_data", 32'(result_data), 32'd4000);
`endif
        rsp_valid = 1'b0;
        req = 4'b0000;
        step();

        // Response arriving on the timeout cycle wins.
        do_reset();
        req_channel[9:5] = 5'd9;
        req = 4'b0010;
        cmd_ready = 1'b1;
        step();
        req = 4'b0000;
        step();
        for (int c = 0; c < T - 1; c++) step();
        rsp_valid = 1'b1; rsp_channel = 5'd9; rsp_data = 12'd3600;
        step();
        check("race_done", 32'(done), 32'h2);
        check("race_err", 32'(result_err), 32'd0);
`ifdef ADC_ARB_OFFSET_EN
        check("race_data", 32'(result_data), 32'd169);
`else
        check("race_data", 32'(result_data), 32'd3600);
`endif
        rsp_valid = 1'b0;
        step();

        // Reset during WAIT_RSP aborts; later response discarded; requester 1 wins.
        do_reset();
        req_channel[4:0] = 5'd17;
        req_channel[9:5] = 5'd17;
        req = 4'b0001;
        cmd_ready = 1'b1;
        step();
        step();
        step();
        check("ab_busy", 32'(busy), 32'd1);
        do_reset();
        cmd_ready = 1'b1;
        rsp_valid = 1'b1; rsp_channel = 5'd17; rsp_data = 12'd2000;
        req = 4'b0010;
        step();
        check("ab_done", 32'(done), 32'd0);
        check("ab_grant", 32'(grant), 32'h2);
        rsp_valid = 1'b0;
        req = 4'b0000;
        for (int c = 0; c < 8; c++) begin
            auto_rsp();
            step();
        end

        // Randomized traffic against the model.
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            int r;
            if ($urandom_range(0, 3) == 0) req = N'($urandom_range(0, 15));
            if ($urandom_range(0, 7) == 0) req_channel = 20'($urandom());
            cmd_ready = ($urandom_range(0, 3) != 0);
            r = $urandom_range(0, 9);
            rsp_data = 12'($urandom());
            if (r < 3) begin
                rsp_valid   = 1'b1;
                rsp_channel = m_ch;
            end else if (r < 6) begin
                rsp_valid   = 1'b1;
                rsp_channel = 5'($urandom());
            end else begin
                rsp_valid   = 1'b0;
                rsp_channel = 5'($urandom());
            end
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
